counter_0_9: RTL and testbench
==============================

// Module: counter_0_9
// PURPOSE
//   Synchronous decimal (mod-10) digit counter with integrated 7-segment decoder.
//   Basic digit cell of the century clock: one instance per displayed digit.
//   Instances cascade by driving the next digit's enable from this digit's done.
//   done is a combinational carry-out, so a whole chain advances on one clock edge.
// PARAMETERS
//   MAX_COUNT       9   terminal count; counts 0..MAX_COUNT then wraps to 0 (legal 1..9)
//   SEG_ACTIVE_LOW  1   1: segment lit when bit = 0 (common-anode); 0: lit when bit = 1
// PORTS
//   clk      in   1  system clock; all state changes on rising edge
//   reset_n  in   1  synchronous, active-low reset
//   enable   in   1  count-enable; advance one step per clock while high
//   done     out  1  carry/terminal pulse: enable high and count == MAX_COUNT
//   seg      out  7  7-segment pattern of current count; seg[0]=a .. seg[6]=g
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-low (reset_n).
//   - State: 4-bit count register; the only state in the block.
//   - Reset: reset_n sampled low at a rising edge -> count = 0 at that edge.
//     Reset has priority over enable. After reset: count=0, seg shows "0", done=0.
//   - reset_n high, enable high, count <  MAX_COUNT -> count+1 at the next edge.
//   - reset_n high, enable high, count == MAX_COUNT -> count wraps to 0 at the next edge.
//   - reset_n high, enable low -> count holds.
//   - Illegal count (> MAX_COUNT, unreachable): next enabled edge forces count to 0.
//   - done = enable & (count == MAX_COUNT); combinational, no register stage.
//     done is high for exactly the cycle whose closing edge performs the wrap.
//     done is low whenever enable is low, including a held count of MAX_COUNT.
//     done does not depend on reset_n; while in reset count=0, so done=0.
//   - seg = combinational decode of the count register; no extra latency.
//     seg changes in the same cycle as the count register.
//   - Active-high patterns (gfedcba), inverted when SEG_ACTIVE_LOW=1:
//     0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//     5=1101101 6=1111101 7=0000111 8=1111111 9=1101111
//   - Decode of codes 10..15: all segments off (blank).
//   - Reset mid-count: count returns to 0 at the reset edge. Any partial progress is lost.
//   - enable toggling mid-sequence: count resumes from the held value, no skip.
//   - No X-propagation on outputs once one reset edge has occurred.
// TESTING
//   1. reset_n=0 for 1 edge with enable=1 -> count=0, seg=7'b1000000, done=0.
//   2. reset_n=1, enable=1 for 9 edges -> seg steps through digits 1..9.
//      Digit 9 shows seg=7'b0010000 and done=1 while enable is high.
//   3. One more enabled edge from 9 -> wraps to 0 (seg=7'b1000000).
//      done falls to 0 after that edge; 12 enabled edges end at count=2.
//   4. Hold at count 9 with enable=0 -> count stays 9, done=0.
//      Then raise enable -> done=1 combinationally in the same cycle.
//   5. reset_n pulsed low for 1 edge at count 5 while enabled -> count=0 at that edge.
//      Counting resumes 1,2,... once reset_n returns high.
//   6. Cascade two instances (units.done -> tens.enable), 10 enabled edges.
//      Result: units=0, tens=1; tens advances exactly once per units wrap.

Source files
------------

// File: rtl/counter_0_9.sv
// Decimal digit counter (0..MAX_COUNT) with a combinational carry-out and a 7-segment decoder.
// Chain digits by driving the next digit's enable from this digit's done.
module counter_0_9 #(
  parameter int unsigned MAX_COUNT      = 9,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       done,
  output logic [6:0] seg
);

  localparam logic [3:0] MaxCount = 4'(MAX_COUNT);

  logic [3:0] count_q, count_d;
  logic [6:0] seg_on;

  // A count above the terminal value (never reached normally) also wraps to 0.
  always_comb begin
    count_d = count_q;
    if (enable) begin
      if (count_q >= MaxCount) count_d = 4'd0;
      else                     count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= 4'd0;
    else          count_q <= count_d;
  end

  assign done = enable && (count_q == MaxCount);

  // Active-high patterns, bit order gfedcba; codes 10..15 are blank.
  always_comb begin
    seg_on = 7'b0000000;
    case (count_q)
      4'd0:    seg_on = 7'b0111111;
      4'd1:    seg_on = 7'b0000110;
      4'd2:    seg_on = 7'b1011011;
      4'd3:    seg_on = 7'b1001111;
      4'd4:    seg_on = 7'b1100110;
      4'd5:    seg_on = 7'b1101101;
      4'd6:    seg_on = 7'b1111101;
      4'd7:    seg_on = 7'b0000111;
      4'd8:    seg_on = 7'b1111111;
      4'd9:    seg_on = 7'b1101111;
      default: seg_on = 7'b0000000;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_on : seg_on;

endmodule

// File: tb/tb_counter_0_9.sv
// Bench for counter_0_9: a cascaded units/tens pair plus a mod-6 active-high digit, checked
// every cycle against an integer model, with directed literal checks and random stimulus.
module tb_counter_0_9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       enable_alt = 1'b0;
  logic       units_done, tens_done, alt_done;
  logic [6:0] units_seg, tens_seg, alt_seg;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_0_9 u_units (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .done   (units_done),
    .seg    (units_seg)
  );

  counter_0_9 u_tens (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (units_done),
    .done   (tens_done),
    .seg    (tens_seg)
  );

  counter_0_9 #(
    .MAX_COUNT     (5),
    .SEG_ACTIVE_LOW(1'b0)
  ) u_alt (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable_alt),
    .done   (alt_done),
    .seg    (alt_seg)
  );

  // Reference model: plain integer digits.
  int m_units = 0, m_tens = 0, m_alt = 0;
  bit armed = 1'b0;

  function automatic logic [6:0] digit_seg(int d, bit active_low);
    logic [6:0] tab [10];
    logic [6:0] p;
    tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    p = (d >= 0 && d <= 9) ? tab[d] : 7'b0000000;
    return active_low ? ~p : p;
  endfunction

  always @(posedge clk) begin
    bit carry;
    carry = enable && (m_units == 9);
    if (!reset_n) begin
      m_units = 0;
      m_tens  = 0;
      m_alt   = 0;
      armed   = 1'b1;
    end else begin
      if (enable)     m_units = (m_units + 1) % 10;
      if (carry)      m_tens  = (m_tens + 1) % 10;
      if (enable_alt) m_alt   = (m_alt + 1) % 6;
    end
  end

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("units_seg", units_seg, digit_seg(m_units, 1'b1));
      check("units_done", {6'd0, units_done}, {6'd0, enable && m_units == 9});
      check("tens_seg", tens_seg, digit_seg(m_tens, 1'b1));
      check("tens_done", {6'd0, tens_done},
            {6'd0, (enable && m_units == 9) && m_tens == 9});
      check("alt_seg", alt_seg, digit_seg(m_alt, 1'b0));
      check("alt_done", {6'd0, alt_done}, {6'd0, enable_alt && m_alt == 5});
    end
  end

  task automatic edges(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 1: reset with enable high
    reset_n = 1'b0; enable = 1'b1; enable_alt = 1'b1;
    edges(1);
    reset_n = 1'b1;
    check("lit_reset_seg", units_seg, 7'b1000000);
    check("lit_reset_done", {6'd0, units_done}, 7'd0);
    check("lit_reset_alt_seg", alt_seg, 7'b0111111);

    // 2: count up to 9
    edges(9);
    check("lit_nine_seg", units_seg, 7'b0010000);
    check("lit_nine_done", {6'd0, units_done}, 7'd1);
    check("lit_tens_still0", tens_seg, 7'b1000000);

    // 3 and 6: wrap, tens takes its single step
    edges(1);
    check("lit_wrap_seg", units_seg, 7'b1000000);
    check("lit_wrap_done", {6'd0, units_done}, 7'd0);
    check("lit_tens_one", tens_seg, 7'b1111001);
    edges(2);
    check("lit_twelve_seg", units_seg, 7'b0100100);

    // 4: hold at 9, then done rises combinationally
    edges(7);
    enable = 1'b0;
    #1;
    check("lit_hold_done", {6'd0, units_done}, 7'd0);
    edges(3);
    check("lit_hold_seg", units_seg, 7'b0010000);
    check("lit_hold_done2", {6'd0, units_done}, 7'd0);
    enable = 1'b1;
    #1;
    check("lit_comb_done", {6'd0, units_done}, 7'd1);

    // 5: reset mid-count at 5
    edges(6);
    check("lit_five_seg", units_seg, 7'b0010010);
    reset_n = 1'b0;
    edges(1);
    reset_n = 1'b1;
    check("lit_midreset_seg", units_seg, 7'b1000000);
    check("lit_midreset_tens", tens_seg, 7'b1000000);
    edges(1);
    check("lit_resume_seg", units_seg, 7'b1111001);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      enable_alt = ($urandom_range(0, 1) != 0);
      reset_n    = ($urandom_range(0, 99) != 0);
      edges(1);
    end
    reset_n = 1'b1;
    edges(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
